// File: rtl/uart_reg_pkg.sv
// Shared protocol constants, parser/scheduler state encoding and reply-length helper
// for the UART register bridge.
package uart_reg_pkg;

  localparam logic [7:0]  HDR        = 8'hA5;
  localparam logic [7:0]  ACK        = 8'h06;
  localparam logic [7:0]  NAK        = 8'h15;
  localparam int unsigned CMD_WR_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_CSUM,
    ST_EXEC,
    ST_TX_LOAD,
    ST_TX_WAIT
  } state_e;

  // Read replies are HDR, CMD, data bytes, CSUM; ACK/NAK replies are one byte.
  function automatic int unsigned reply_len(input logic is_read, input int unsigned bytes);
    return is_read ? (bytes + 32'd3) : 32'd1;
  endfunction

endpackage

// File: rtl/byte_tx_sched.sv
// Reply byte scheduler: latches a reply buffer and feeds it byte by byte to the
// UART transmitter using a send strobe and the transmitter busy flag.
// Ports: clk_in/reset (sync, active-high); load_i/buf_i/len_i load a reply
// (byte k at buf_i[k*8 +: 8]); tx_busy_i/tx_send_o/tx_data_o UART handshake;
// done_o pulses one cycle after the last byte has been accepted.
module byte_tx_sched
  import uart_reg_pkg::*;
#(
  parameter int unsigned MAX_LEN = 5,
  parameter int unsigned LEN_W   = 3
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [MAX_LEN*8-1:0] buf_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic                 tx_busy_i,
  output logic                 tx_send_o,
  output logic [7:0]           tx_data_o,
  output logic                 done_o
);

  state_e               r_state;
  logic [MAX_LEN*8-1:0] r_buf;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_idx;
  logic                 r_guard;
  logic                 r_send;
  logic [7:0]           r_data;
  logic                 r_done;
  logic [7:0]           w_byte;

  assign w_byte = 8'(r_buf >> {r_idx, 3'b000});

  // Send one byte per TX_LOAD; TX_WAIT skips one guard cycle so the busy flag
  // raised by the transmitter in response to the strobe is seen before release.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_buf   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_guard <= 1'b0;
      r_send  <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_send <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load_i) begin
            r_buf   <= buf_i;
            r_len   <= len_i;
            r_idx   <= '0;
            r_state <= ST_TX_LOAD;
          end
        end
        ST_TX_LOAD: begin
          if (!tx_busy_i) begin
            r_send  <= 1'b1;
            r_data  <= w_byte;
            r_guard <= 1'b1;
            r_state <= ST_TX_WAIT;
          end
        end
        ST_TX_WAIT: begin
          if (r_guard) begin
            r_guard <= 1'b0;
          end else if (!tx_busy_i) begin
            if (r_idx == r_len - LEN_W'(1)) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_idx   <= r_idx + LEN_W'(1);
              r_state <= ST_TX_LOAD;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_send_o = r_send;
  assign tx_data_o = r_data;
  assign done_o    = r_done;

endmodule

// File: rtl/uart_reg_bridge.sv
// UART register bridge: parses checksummed read/write frames from the UART
// receive stream into a register bank and replies with ACK/NAK or read frames.
// Ports: clk_in/reset (sync, active-high); rx_valid_i/rx_data_i received bytes;
// tx_busy_i/tx_send_o/tx_data_o transmit handshake; regs_o flattened bank
// (reg i at [i*DATA_W +: DATA_W]); wr_strobe_o per-register update pulse;
// err_cnt_o saturating rejected-frame count.
module uart_reg_bridge
  import uart_reg_pkg::*;
#(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       NUM_REGS    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0,
  parameter int unsigned       TIMEOUT_CYC = 100000
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         rx_valid_i,
  input  logic [7:0]                   rx_data_i,
  input  logic                         tx_busy_i,
  output logic                         tx_send_o,
  output logic [7:0]                   tx_data_o,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic [NUM_REGS-1:0]          wr_strobe_o,
  output logic [7:0]                   err_cnt_o
);

  localparam int unsigned BYTES   = DATA_W / 8;
  localparam int unsigned MAX_LEN = BYTES + 3;
  localparam int unsigned BUF_W   = MAX_LEN * 8;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
  localparam int unsigned CNT_W   = $clog2(BYTES + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC + 1);

  state_e              r_state;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [7:0]          r_cmd;
  logic [DATA_W-1:0]   r_data;
  logic [CNT_W-1:0]    r_cnt;
  logic [7:0]          r_csum;
  logic                r_csum_ok;
  logic [TO_W-1:0]     r_to_cnt;
  logic [7:0]          r_err;
  logic [NUM_REGS-1:0] r_wr_strobe;
  logic                r_load;
  logic [BUF_W-1:0]    r_buf;
  logic [LEN_W-1:0]    r_len;

  logic [6:0]          w_addr;
  logic                w_addr_ok;
  logic                w_is_wr;
  logic [DATA_W-1:0]   w_rd_data;
  logic [BUF_W-1:0]    w_rd_buf;
  logic [7:0]          w_rd_csum;
  logic                w_tx_done;

  assign w_addr    = r_cmd[6:0];
  assign w_is_wr   = r_cmd[CMD_WR_BIT];
  assign w_addr_ok = {25'b0, w_addr} < NUM_REGS;

  // Read-data mux; out-of-range addresses never reach a read reply.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_addr == 7'(i)) w_rd_data = r_regs[i];
    end
  end

  // Read reply frame: HDR, CMD, data MSB first, XOR of all preceding bytes.
  always_comb begin
    w_rd_buf  = '0;
    w_rd_csum = HDR ^ r_cmd;
    w_rd_buf[7:0]  = HDR;
    w_rd_buf[15:8] = r_cmd;
    for (int k = 0; k < BYTES; k++) begin
      w_rd_buf[(2 + k) * 8 +: 8] = w_rd_data[(BYTES - 1 - k) * 8 +: 8];
      w_rd_csum = w_rd_csum ^ w_rd_data[(BYTES - 1 - k) * 8 +: 8];
    end
    w_rd_buf[(MAX_LEN - 1) * 8 +: 8] = w_rd_csum;
  end

  // Frame parser, register bank and error counter.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
      r_cmd       <= '0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_csum      <= '0;
      r_csum_ok   <= 1'b0;
      r_to_cnt    <= '0;
      r_err       <= '0;
      r_wr_strobe <= '0;
      r_load      <= 1'b0;
      r_buf       <= '0;
      r_len       <= '0;
    end else begin
      r_wr_strobe <= '0;
      r_load      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rx_valid_i && rx_data_i == HDR) begin
            r_csum   <= HDR;
            r_to_cnt <= '0;
            r_state  <= ST_CMD;
          end
        end
        ST_CMD, ST_DATA, ST_CSUM: begin
          if (rx_valid_i) begin
            r_to_cnt <= '0;
            r_csum   <= r_csum ^ rx_data_i;
            if (r_state == ST_CMD) begin
              r_cmd   <= rx_data_i;
              r_cnt   <= '0;
              r_state <= rx_data_i[CMD_WR_BIT] ? ST_DATA : ST_CSUM;
            end else if (r_state == ST_DATA) begin
              r_data <= DATA_W'({r_data, rx_data_i});
              if (r_cnt == CNT_W'(BYTES - 1)) r_state <= ST_CSUM;
              else                            r_cnt   <= r_cnt + CNT_W'(1);
            end else begin
              r_csum_ok <= (rx_data_i == r_csum);
              r_state   <= ST_EXEC;
            end
          end else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
            r_state <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_EXEC: begin
          r_load  <= 1'b1;
          r_state <= ST_TX_LOAD;
          if (r_csum_ok && w_addr_ok) begin
            if (w_is_wr) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (w_addr == 7'(i)) begin
                  r_regs[i]      <= r_data;
                  r_wr_strobe[i] <= 1'b1;
                end
              end
              r_buf <= BUF_W'(ACK);
              r_len <= LEN_W'(reply_len(1'b0, BYTES));
            end else begin
              r_buf <= w_rd_buf;
              r_len <= LEN_W'(reply_len(1'b1, BYTES));
            end
          end else begin
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
            r_buf <= BUF_W'(NAK);
            r_len <= LEN_W'(reply_len(1'b0, BYTES));
          end
        end
        ST_TX_LOAD, ST_TX_WAIT: begin
          // Reply in flight; received bytes are dropped until it completes.
          if (w_tx_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  byte_tx_sched #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_tx_sched (
    .clk_in    (clk_in),
    .reset     (reset),
    .load_i    (r_load),
    .buf_i     (r_buf),
    .len_i     (r_len),
    .tx_busy_i (tx_busy_i),
    .tx_send_o (tx_send_o),
    .tx_data_o (tx_data_o),
    .done_o    (w_tx_done)
  );

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs_o[g * DATA_W +: DATA_W] = r_regs[g];
  end

  assign wr_strobe_o = r_wr_strobe;
  assign err_cnt_o   = r_err;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge with a busy-holding UART transmitter model.
module tb_uart_reg_bridge;

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 8;
  localparam int unsigned TO = 40;

  logic               clk_in = 1'b0;
  logic               reset;
  logic               rx_valid_i;
  logic [7:0]         rx_data_i;
  logic               tx_busy_i;
  logic               tx_send_o;
  logic [7:0]         tx_data_o;
  logic [NR*DW-1:0]   regs_o;
  logic [NR-1:0]      wr_strobe_o;
  logic [7:0]         err_cnt_o;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] q[$];
  int         busy_cnt = 0;
  int         viol = 0;
  int         strobes = 0;

  uart_reg_bridge #(
    .DATA_W      (DW),
    .NUM_REGS    (NR),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .tx_busy_i   (tx_busy_i),
    .tx_send_o   (tx_send_o),
    .tx_data_o   (tx_data_o),
    .regs_o      (regs_o),
    .wr_strobe_o (wr_strobe_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk_in = ~clk_in;

  // UART transmitter model: captures each sent byte and stays busy 10 cycles.
  assign tx_busy_i = (busy_cnt != 0);
  always @(posedge clk_in) begin
    if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (tx_send_o) begin
      if (tx_busy_i) viol <= viol + 1;
      q.push_back(tx_data_o);
      busy_cnt <= 10;
    end
  end

  always @(negedge clk_in) if (wr_strobe_o != '0) strobes++;

  function automatic logic [15:0] rg(input int i);
    return regs_o[i*DW +: DW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(negedge clk_in);
    rx_valid_i = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic frame3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a); send(b); send(c);
  endtask

  task automatic frame5(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input logic [7:0] e);
    send(a); send(b); send(c); send(d); send(e);
  endtask

  task automatic wait_q(input int n);
    int k = 0;
    while (q.size() < n && k < 3000) begin
      @(negedge clk_in);
      k++;
    end
  endtask

  task automatic get_reply(input string tag, input int n);
    wait_q(n);
    repeat (20) @(negedge clk_in);
    chk({tag, "_len"}, 64'(q.size()), 64'(n));
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    logic [15:0] obs;
    if (q.size() > 0) obs = {8'h00, q.pop_front()};
    else              obs = 16'hDEAD;
    chk(tag, 64'(obs), 64'(exp));
  endtask

  initial begin
    int s0;
    int n0;
    int nak_bad;
    reset      = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);

    chk("rst_regs_lo", regs_o[63:0], 64'h0);
    chk("rst_regs_hi", regs_o[127:64], 64'h0);
    chk("rst_err", 64'(err_cnt_o), 64'h0);
    chk("rst_send", 64'(tx_send_o), 64'h0);
    chk("rst_txdata", 64'(tx_data_o), 64'h0);

    // Write reg3 = 0x1234 with strobe timing at t+2.
    send(8'hA5); send(8'h83); send(8'h12); send(8'h34);
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h00;
    @(negedge clk_in);
    rx_valid_i = 1'b0;
    chk("wr_t1_strobe", 64'(wr_strobe_o), 64'h0);
    chk("wr_t1_reg3", 64'(rg(3)), 64'h0);
    @(negedge clk_in);
    chk("wr_t2_strobe", 64'(wr_strobe_o), 64'h08);
    chk("wr_t2_reg3", 64'(rg(3)), 64'h1234);
    @(negedge clk_in);
    chk("wr_t3_strobe", 64'(wr_strobe_o), 64'h0);
    get_reply("ack1", 1);
    pop_chk("ack1_byte", 8'h06);
    chk("ack1_err", 64'(err_cnt_o), 64'h0);

    // Read reg3.
    frame3(8'hA5, 8'h03, 8'hA6);
    get_reply("rd1", 5);
    pop_chk("rd1_b0", 8'hA5);
    pop_chk("rd1_b1", 8'h03);
    pop_chk("rd1_b2", 8'h12);
    pop_chk("rd1_b3", 8'h34);
    pop_chk("rd1_b4", 8'h80);

    // Bad checksum.
    s0 = strobes;
    frame5(8'hA5, 8'h83, 8'h12, 8'h34, 8'hFF);
    get_reply("badcs", 1);
    pop_chk("badcs_nak", 8'h15);
    chk("badcs_reg3", 64'(rg(3)), 64'h1234);
    chk("badcs_strobe", 64'(strobes), 64'(s0));
    chk("badcs_err", 64'(err_cnt_o), 64'h1);

    // Address out of range.
    frame5(8'hA5, 8'h8A, 8'h00, 8'h01, 8'h2E);
    get_reply("badaddr", 1);
    pop_chk("badaddr_nak", 8'h15);
    chk("badaddr_err", 64'(err_cnt_o), 64'h2);
    chk("badaddr_strobe", 64'(strobes), 64'(s0));

    // Leading junk then an abandoned frame times out.
    send(8'h00); send(8'h7F); send(8'hA5); send(8'h83); send(8'h12);
    repeat (TO + 10) @(negedge clk_in);
    chk("to_notx", 64'(q.size()), 64'h0);
    chk("to_err", 64'(err_cnt_o), 64'h3);
    frame5(8'hA5, 8'h83, 8'hBE, 8'hEF, 8'h77);
    get_reply("to_ack", 1);
    pop_chk("to_ack_byte", 8'h06);
    chk("to_reg3", 64'(rg(3)), 64'hBEEF);
    chk("to_err2", 64'(err_cnt_o), 64'h3);

    // Reset in the middle of a read reply.
    frame3(8'hA5, 8'h03, 8'hA6);
    wait_q(2);
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    n0 = q.size();
    chk("rstrep_txdata", 64'(tx_data_o), 64'h0);
    repeat (60) @(negedge clk_in);
    chk("rstrep_nosend", 64'(q.size()), 64'(n0));
    chk("rstrep_regs_lo", regs_o[63:0], 64'h0);
    chk("rstrep_regs_hi", regs_o[127:64], 64'h0);
    chk("rstrep_err", 64'(err_cnt_o), 64'h0);
    q.delete();

    // Reset in the middle of a frame, then a fresh write.
    send(8'hA5); send(8'h83); send(8'h12);
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    frame5(8'hA5, 8'h81, 8'h00, 8'h05, 8'h21);
    get_reply("rstfr", 1);
    pop_chk("rstfr_ack", 8'h06);
    chk("rstfr_reg1", 64'(rg(1)), 64'h0005);
    chk("rstfr_reg3", 64'(rg(3)), 64'h0);
    chk("rstfr_err", 64'(err_cnt_o), 64'h0);

    // Bytes arriving during a read reply are ignored.
    s0 = strobes;
    frame3(8'hA5, 8'h01, 8'hA4);
    wait_q(1);
    frame5(8'hA5, 8'h83, 8'h12, 8'h34, 8'h00);
    get_reply("inj", 5);
    pop_chk("inj_b0", 8'hA5);
    pop_chk("inj_b1", 8'h01);
    pop_chk("inj_b2", 8'h00);
    pop_chk("inj_b3", 8'h05);
    pop_chk("inj_b4", 8'hA1);
    chk("inj_reg3", 64'(rg(3)), 64'h0);
    chk("inj_strobe", 64'(strobes), 64'(s0));
    chk("inj_err", 64'(err_cnt_o), 64'h0);

    // Error counter saturation.
    nak_bad = 0;
    for (int i = 0; i < 260; i++) begin
      frame5(8'hA5, 8'h83, 8'h12, 8'h34, 8'hFF);
      wait_q(1);
      repeat (20) @(negedge clk_in);
      if (q.size() != 1) nak_bad++;
      else if (q.pop_front() != 8'h15) nak_bad++;
      q.delete();
      if (i == 253) chk("sat_err_254", 64'(err_cnt_o), 64'd254);
    end
    chk("sat_naks", 64'(nak_bad), 64'h0);
    chk("sat_err", 64'(err_cnt_o), 64'hFF);
    chk("sat_reg3", 64'(rg(3)), 64'h0);

    chk("tx_busy_viol", 64'(viol), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
Parametrised successor to the single-register serial memory controller and memory pair, merged into one block. Parses framed, checksummed read/write commands from the UART receive byte stream into an internal bank of NUM_REGS registers of DATA_W bits, which supply coefficients to multiple PID channels. Replies through the UART transmit handshake with ACK/NAK bytes or read-data frames. Sits between the UART and the PID datapath in the top-level wrapper, replacing the separate controller and memory.

Parameters:
DATA_W, 16, register width in bits; multiple of 8, 8..32; BYTES = DATA_W/8
NUM_REGS, 8, register count, 1..128 (7-bit protocol address)
RESET_VAL, 0, value loaded into every register on reset
TIMEOUT_CYC, 100000, max idle clk_in cycles between bytes of one frame; >= 2

Ports:
clk_in  input  1  system clock; single clock domain
reset  input  1  synchronous, active-high reset
rx_valid_i  input  1  one-cycle strobe: rx_data_i holds a received byte
rx_data_i  input  8  received byte
tx_busy_i  input  1  UART transmitter busy
tx_send_o  output  1  one-cycle strobe: transmit tx_data_o
tx_data_o  output  8  byte to transmit; held stable until the next send
regs_o  output  NUM_REGS*DATA_W  flattened register bank; reg i at [i*DATA_W +: DATA_W]
wr_strobe_o  output  NUM_REGS  one-cycle pulse on reg i the cycle its new value first appears
err_cnt_o  output  8  saturating count of rejected frames

Behaviour:
- Reset (synchronous, active-high; also mid-frame or mid-reply): every reg = RESET_VAL; tx_send_o=0, tx_data_o=0, wr_strobe_o=0, err_cnt_o=0; FSM to IDLE; partial frame discarded.
- Frame: HDR(0xA5), CMD, [BYTES data bytes, MSB first, write only], CSUM. CMD[7]=1 write, 0 read; CMD[6:0]=address. CSUM = XOR of all preceding frame bytes including HDR.
- FSM states: IDLE, CMD, DATA, CSUM, EXEC, TX_LOAD, TX_WAIT.
- IDLE: bytes other than 0xA5 are dropped silently and not counted.
- CMD -> DATA on a write, CSUM on a read. DATA counts BYTES bytes, then CSUM.
- In CMD, DATA and CSUM the timeout counter clears on every accepted byte. At TIMEOUT_CYC with no byte: return to IDLE, err_cnt +1, no reply.
- EXEC, valid write (checksum OK, addr < NUM_REGS): reg written. With CSUM accepted in cycle t, regs_o shows the new value and wr_strobe_o[addr]=1 in cycle t+2 only. Reply 0x06 (ACK).
- EXEC, valid read: reply A5, CMD, BYTES data bytes MSB first, CSUM (XOR of the preceding reply bytes). Data is sampled in EXEC.
- EXEC, bad checksum or addr >= NUM_REGS: no write, no strobe, err_cnt +1, reply 0x15 (NAK).
- err_cnt_o saturates at 0xFF.
- TX handshake: in TX_LOAD with tx_busy_i=0, pulse tx_send_o for 1 cycle with tx_data_o valid, then enter TX_WAIT. TX_WAIT ignores busy for 1 guard cycle, then waits for tx_busy_i=0. After the last reply byte, return to IDLE.
- rx_valid_i during EXEC, TX_LOAD or TX_WAIT: byte dropped, not counted.
- Write and read of the same register never overlap because commands are serialised.

Decomposition:
- Package uart_reg_pkg: HDR=8'hA5, ACK=8'h06, NAK=8'h15, CMD_WR_BIT=7, FSM state enum, reply-length helper function.
- Sub-module byte_tx_sched: holds a reply buffer of up to BYTES+3 bytes plus length, and runs the TX_LOAD/TX_WAIT handshake. The parser loads the buffer in EXEC and waits for done.

Test Plan:
- Defaults; send A5 83 12 34 00 -> regs[3]=0x1234 with wr_strobe_o=8'b0000_1000 for exactly 1 cycle at t+2; TX byte 06; err_cnt 0.
- Then send A5 03 A6 -> TX bytes A5 03 12 34 80, each sent only while tx_busy_i=0; UART model holds busy for 10 cycles per byte.
- Send A5 83 12 34 FF (bad CSUM) -> regs[3] unchanged, no strobe, TX 15, err_cnt 1. Send A5 8A 00 01 2E (addr 10 >= 8) -> TX 15, err_cnt 2.
- Send 00 7F A5 83 12, then idle TIMEOUT_CYC cycles -> no TX, err_cnt +1. Send the full write frame again -> accepted, ACK. Leading junk 00 7F is not counted.
- Assert reset for 1 cycle mid-reply and mid-frame -> all regs=RESET_VAL, err_cnt 0, tx_send_o stays 0. The next valid frame succeeds.
- Drive rx bytes during the read reply, and force err_cnt to 255 with 260 bad frames -> injected bytes ignored, err_cnt_o holds at 0xFF.
